// File: rtl/wave_pkg.sv
// wave_pkg: shared constants for the wave_shaper sample generator.
// Provides the wave-select encodings and the default sample/phase widths.
package wave_pkg;
    localparam int DEF_DATA_W  = 8;
    localparam int DEF_PHASE_W = 9;

    localparam logic [1:0] WAVE_SQUARE = 2'd0;
    localparam logic [1:0] WAVE_SAW    = 2'd1;
    localparam logic [1:0] WAVE_TRI    = 2'd2;
    localparam logic [1:0] WAVE_OFF    = 2'd3;
endpackage

// File: rtl/wave_shape.sv
// wave_shape: combinational phase-to-sample shaper.
// Ports: phase (PHASE_W) accumulator value, sel (2) waveform select,
//        duty (DATA_W) square threshold, sample (DATA_W) shaped output word.
module wave_shape
    import wave_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int PHASE_W = DEF_PHASE_W
) (
    input  logic [PHASE_W-1:0] phase,
    input  logic [1:0]         sel,
    input  logic [DATA_W-1:0]  duty,
    output logic [DATA_W-1:0]  sample
);
    logic [DATA_W-1:0] w_hi;
    logic [DATA_W-1:0] w_lo;

    assign w_hi = phase[PHASE_W-1 -: DATA_W];
    // One bit finer than w_hi so the triangle ramps up and down within one period.
    assign w_lo = phase[PHASE_W-2 -: DATA_W];

    always_comb begin
        sample = (sel == WAVE_SQUARE) ? {DATA_W{w_hi < duty}} :
                 (sel == WAVE_SAW)    ? w_hi :
                 (sel == WAVE_TRI)    ? (phase[PHASE_W-1] ? ~w_lo : w_lo) :
                                        DATA_W'(1) << (DATA_W-1);
    end
endmodule

// File: rtl/wave_shaper.sv
// wave_shaper: divider-strobed phase accumulator producing square/saw/triangle samples.
// Ports: ref_clk clock, rst sync active-high reset, tick_in divider output (rising edge = step),
//        enable run/freeze, wave_sel waveform, duty square threshold,
//        sample output word, sample_valid update pulse, period_start phase-0 pulse.
module wave_shaper
    import wave_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int PHASE_W = DEF_PHASE_W
) (
    input  logic              ref_clk,
    input  logic              rst,
    input  logic              tick_in,
    input  logic              enable,
    input  logic [1:0]        wave_sel,
    input  logic [DATA_W-1:0] duty,
    output logic [DATA_W-1:0] sample,
    output logic              sample_valid,
    output logic              period_start
);
    logic               r_tick_d;
    logic               r_step_d;
    logic [PHASE_W-1:0] r_phase;
    logic [1:0]         r_sel;
    logic [DATA_W-1:0]  r_duty;

    logic               w_step;
    logic               w_upd;
    logic [PHASE_W-1:0] w_phase_nxt;
    logic [DATA_W-1:0]  w_shape;

    assign w_step      = tick_in & ~r_tick_d & enable;
    assign w_upd       = r_step_d & enable;
    assign w_phase_nxt = r_phase + 1'b1;

    wave_shape #(.DATA_W(DATA_W), .PHASE_W(PHASE_W)) u_shape (
        .phase  (r_phase),
        .sel    (r_sel),
        .duty   (r_duty),
        .sample (w_shape)
    );

    always_ff @(posedge ref_clk) begin
        if (rst) begin
            r_tick_d     <= 1'b0;
            r_step_d     <= 1'b0;
            r_phase      <= '0;
            r_sel        <= wave_sel;
            r_duty       <= duty;
            sample       <= '0;
            sample_valid <= 1'b0;
            period_start <= 1'b0;
        end else begin
            // Edge history tracks tick_in even when frozen, so a held tick never counts on enable.
            r_tick_d     <= tick_in;
            r_step_d     <= w_step;
            if (w_step) begin
                r_phase <= w_phase_nxt;
                // Config is only adopted at a period boundary so waveforms never glitch.
                if (w_phase_nxt == '0) begin
                    r_sel  <= wave_sel;
                    r_duty <= duty;
                end
            end
            if (w_upd)
                sample <= w_shape;
            sample_valid <= w_upd;
            period_start <= w_upd && (r_phase == '0);
        end
    end
endmodule

// File: tb/tb_wave_shaper.sv
// tb_wave_shaper: directed table-driven bench for wave_shaper with DATA_W=8, PHASE_W=9.
module tb_wave_shaper;
    logic       ref_clk = 1'b0;
    logic       rst;
    logic       tick_in;
    logic       enable;
    logic [1:0] wave_sel;
    logic [7:0] duty;
    logic [7:0] sample;
    logic       sample_valid;
    logic       period_start;

    int errs   = 0;
    int checks = 0;

    typedef struct {
        logic [1:0] sel;
        logic [7:0] duty;
        int         n;
        logic [7:0] exp;
        logic       ps;
        string      nm;
    } vec_t;

    vec_t vt[$];

    always #5 ref_clk = ~ref_clk;

    wave_shaper #(.DATA_W(8), .PHASE_W(9)) dut (
        .ref_clk      (ref_clk),
        .rst          (rst),
        .tick_in      (tick_in),
        .enable       (enable),
        .wave_sel     (wave_sel),
        .duty         (duty),
        .sample       (sample),
        .sample_valid (sample_valid),
        .period_start (period_start)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
        end
    endtask

    // Called right after a negedge; drives one high and one low ref_clk period.
    task automatic tick(input bit chkv);
        tick_in = 1'b1;
        @(negedge ref_clk);
        if (chkv) chk("valid_low_at_k", {31'b0, sample_valid}, 32'd0);
        tick_in = 1'b0;
        @(negedge ref_clk);
        if (chkv) chk("valid_high_at_k1", {31'b0, sample_valid}, 32'd1);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick(1'b1);
    endtask

    task automatic do_reset(input logic [1:0] sel, input logic [7:0] d);
        rst      = 1'b1;
        wave_sel = sel;
        duty     = d;
        tick_in  = 1'b0;
        enable   = 1'b1;
        @(negedge ref_clk);
        @(negedge ref_clk);
        rst = 1'b0;
    endtask

    initial begin
        int pulses;
        rst = 1'b1; tick_in = 1'b0; enable = 1'b1; wave_sel = 2'd1; duty = 8'h00;
        @(negedge ref_clk);
        @(negedge ref_clk);
        chk("reset_sample", {24'b0, sample}, 32'h00);
        chk("reset_valid", {31'b0, sample_valid}, 32'd0);
        chk("reset_pstart", {31'b0, period_start}, 32'd0);
        rst = 1'b0;

        vt.push_back(vec_t'{2'd1, 8'h00,   1, 8'h00, 1'b0, "saw_t1"});
        vt.push_back(vec_t'{2'd1, 8'h00,   2, 8'h01, 1'b0, "saw_t2"});
        vt.push_back(vec_t'{2'd1, 8'h00,   3, 8'h01, 1'b0, "saw_t3"});
        vt.push_back(vec_t'{2'd1, 8'h00,   4, 8'h02, 1'b0, "saw_t4"});
        vt.push_back(vec_t'{2'd2, 8'h00, 255, 8'hFF, 1'b0, "tri_p255"});
        vt.push_back(vec_t'{2'd2, 8'h00, 256, 8'hFF, 1'b0, "tri_p256"});
        vt.push_back(vec_t'{2'd2, 8'h00, 511, 8'h00, 1'b0, "tri_p511"});
        vt.push_back(vec_t'{2'd2, 8'h00, 512, 8'h00, 1'b1, "tri_p0"});
        vt.push_back(vec_t'{2'd0, 8'h80, 254, 8'hFF, 1'b0, "sq80_p254"});
        vt.push_back(vec_t'{2'd0, 8'h80, 255, 8'hFF, 1'b0, "sq80_p255"});
        vt.push_back(vec_t'{2'd0, 8'h80, 256, 8'h00, 1'b0, "sq80_p256"});
        vt.push_back(vec_t'{2'd0, 8'h00, 254, 8'h00, 1'b0, "sq00_p254"});
        vt.push_back(vec_t'{2'd0, 8'h00,  10, 8'h00, 1'b0, "sq00_p10"});
        vt.push_back(vec_t'{2'd3, 8'h00,   5, 8'h80, 1'b0, "off_p5"});
        vt.push_back(vec_t'{2'd1, 8'h00, 511, 8'hFF, 1'b0, "saw_p511"});

        foreach (vt[i]) begin
            do_reset(vt[i].sel, vt[i].duty);
            ticks(vt[i].n);
            chk({vt[i].nm, "_sample"}, {24'b0, sample}, {24'b0, vt[i].exp});
            chk({vt[i].nm, "_pstart"}, {31'b0, period_start}, {31'b0, vt[i].ps});
            @(negedge ref_clk);
            chk({vt[i].nm, "_valid_drop"}, {31'b0, sample_valid}, 32'd0);
        end

        // Mid-period select change is deferred to the period boundary.
        do_reset(2'd1, 8'h00);
        ticks(100);
        wave_sel = 2'd2;
        ticks(1);
        chk("sw_p101_saw", {24'b0, sample}, 32'h32);
        ticks(410);
        chk("sw_p511_saw", {24'b0, sample}, 32'hFF);
        ticks(1);
        chk("sw_p0_tri", {24'b0, sample}, 32'h00);
        chk("sw_p0_pstart", {31'b0, period_start}, 32'd1);
        ticks(1);
        chk("sw_p1_tri", {24'b0, sample}, 32'h01);

        // Freeze with enable low, then a held tick across enable rising.
        do_reset(2'd1, 8'h00);
        ticks(10);
        enable = 1'b0;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            tick_in = 1'b1;
            @(negedge ref_clk);
            pulses += int'(sample_valid);
            tick_in = 1'b0;
            @(negedge ref_clk);
            pulses += int'(sample_valid);
        end
        chk("en0_pulses", pulses, 32'd0);
        chk("en0_phase", {23'b0, dut.r_phase}, 32'd10);
        chk("en0_sample", {24'b0, sample}, 32'h05);
        tick_in = 1'b1;
        @(negedge ref_clk);
        @(negedge ref_clk);
        enable = 1'b1;
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge ref_clk);
            pulses += int'(sample_valid);
        end
        chk("held_pulses", pulses, 32'd0);
        chk("held_phase", {23'b0, dut.r_phase}, 32'd10);
        tick_in = 1'b0;
        @(negedge ref_clk);
        ticks(1);
        chk("held_next_phase", {23'b0, dut.r_phase}, 32'd11);
        chk("held_next_sample", {24'b0, sample}, 32'h05);

        // Reset coincident with a tick edge.
        do_reset(2'd1, 8'h00);
        ticks(300);
        chk("pre_rst_sample", {24'b0, sample}, 32'h96);
        tick_in = 1'b1;
        rst = 1'b1;
        @(negedge ref_clk);
        chk("mrst_sample", {24'b0, sample}, 32'h00);
        chk("mrst_valid", {31'b0, sample_valid}, 32'd0);
        chk("mrst_phase", {23'b0, dut.r_phase}, 32'd0);
        rst = 1'b0;
        tick_in = 1'b0;
        @(negedge ref_clk);
        chk("mrst_valid2", {31'b0, sample_valid}, 32'd0);
        ticks(1);
        chk("mrst_step_phase", {23'b0, dut.r_phase}, 32'd1);
        chk("mrst_step_sample", {24'b0, sample}, 32'h00);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
